// File: rtl/fht_input_loader.sv
// Stream front end of the FHT core: scatters one frame of 4*2^A_BIT samples into
// four input RAM banks in bit-reversed order, then kicks fht_control and waits for it.
module fht_input_loader #(
   parameter int A_BIT = 8,
   parameter int D_BIT = 16
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic [D_BIT-1:0] iDATA,
   input  logic             iVALID,
   output logic             oREADY,
   input  logic             iFHT_RDY,
   output logic             oSTART,
   output logic [A_BIT-1:0] oADDR_WR,
   output logic [D_BIT-1:0] oDATA_WR,
   output logic [3:0]       oWE,
   output logic             oBUSY,
   output logic             oOVERRUN
);

   localparam int K_BIT = A_BIT + 2;

   typedef enum logic [2:0] {
      LOAD,
      FLUSH,
      START,
      WAIT_ACK,
      WAIT_DONE
   } state_t;

   state_t           state;
   logic [K_BIT-1:0] k;
   logic [K_BIT-1:0] r;
   logic             xfer;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      r = '0;
      for (int i = 0; i < K_BIT; i++) r[i] = k[K_BIT-1-i];
   end

   // Ready is a pure state decode; masking with reset keeps it low while held in reset.
   assign oREADY = (state == LOAD) && !iRESET;
   assign xfer   = iVALID && oREADY;

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         state    <= LOAD;
         k        <= '0;
         oSTART   <= 1'b0;
         oWE      <= '0;
         oADDR_WR <= '0;
         oDATA_WR <= '0;
         oBUSY    <= 1'b0;
         oOVERRUN <= 1'b0;
      end else begin
         oWE    <= '0;
         oSTART <= 1'b0;
         if (iVALID && state != LOAD) oOVERRUN <= 1'b1;

         case (state)
            LOAD: begin
               if (xfer) begin
                  oDATA_WR <= iDATA;
                  oADDR_WR <= r[K_BIT-1:2];
                  oWE      <= 4'b0001 << r[1:0];
                  oBUSY    <= 1'b1;
                  k        <= k + 1'b1;
                  if (&k) state <= FLUSH;
               end
            end
            FLUSH: begin
               // The last write is on the bus now; the pulse lands one cycle later.
               oSTART <= 1'b1;
               state  <= START;
            end
            START:     state <= WAIT_ACK;
            WAIT_ACK:  if (!iFHT_RDY) state <= WAIT_DONE;
            WAIT_DONE: begin
               if (iFHT_RDY) begin
                  oBUSY <= 1'b0;
                  state <= LOAD;
               end
            end
            default:   state <= LOAD;
         endcase
      end
   end

endmodule

// File: doc/fht_input_loader.md
Name: fht_input_loader

Overview:
- Front end of the FHT core, directly upstream of fht_control.
- Accepts one frame of N = 4·2^A_BIT samples over a valid/ready stream and writes each sample into the four input RAM banks in bit-reversed order.
- Once the frame is written, issues a one-cycle start pulse to fht_control, then holds off new input until the transform reports ready again.

Parameters:
- A_BIT, 8, address width of one bank; the frame holds 4·2^A_BIT points.
- D_BIT, 16, sample width.

Ports:
- iCLK  in  1  system clock; all logic on its rising edge.
- iRESET  in  1  asynchronous, active-high reset.
- iDATA  in  D_BIT  input sample.
- iVALID  in  1  iDATA is valid this cycle.
- oREADY  out  1  loader accepts a sample this cycle; transfer occurs when iVALID & oREADY.
- iFHT_RDY  in  1  ready flag from fht_control (oRDY): high = idle/done, low = transform running.
- oSTART  out  1  one-cycle start pulse to fht_control (iSTART).
- oADDR_WR  out  A_BIT  write address, common to all banks.
- oDATA_WR  out  D_BIT  write data, common to all banks.
- oWE  out  4  one-hot bank write enables; bit b writes bank b.
- oBUSY  out  1  high from first accepted sample until the transform completes.
- oOVERRUN  out  1  sticky; set when iVALID is high while the loader is not in LOAD.

Behaviour:
- Reset (async, iRESET=1) clears everything:
  - state=LOAD, sample counter k=0
  - oREADY=0 while in reset, 1 in the first cycle after release
  - oSTART=0, oWE=0, oADDR_WR=0, oDATA_WR=0, oBUSY=0, oOVERRUN=0
- Reset mid-frame discards the partial frame with no start pulse. Reset while the FHT runs returns the loader to LOAD immediately; fht_control state is not touched.
- Index mapping:
  - k is A_BIT+2 bits wide; r = bit-reverse of k over A_BIT+2 bits.
  - Bank = r[1:0], address = r[A_BIT+1:2].
- States:
  - LOAD: oREADY=1. Each transfer registers oDATA_WR=iDATA, oADDR_WR=r[A_BIT+1:2], oWE=one-hot(r[1:0]); these appear exactly 1 cycle after acceptance. oWE=0 in any cycle following a non-transfer cycle. k increments per transfer; oBUSY is set on the first transfer. A transfer with k = N-1 moves to FLUSH, and k wraps to 0.
  - FLUSH: oREADY=0; the final write is on the outputs this cycle. Next state is START.
  - START: oSTART=1 for exactly this cycle. Next state is WAIT_ACK.
  - WAIT_ACK: wait for iFHT_RDY=0, then go to WAIT_DONE.
  - WAIT_DONE: wait for iFHT_RDY=1, then clear oBUSY and go to LOAD. oREADY rises in the cycle after iFHT_RDY is sampled high.
- Timing of the final sample: accepted at cycle t, written at t+1 (FLUSH), oSTART at t+2. The start pulse never coincides with an oWE bit.
- Output registration: oSTART, oWE, oADDR_WR, oDATA_WR are registered. oREADY is decoded from the state register only, with no combinational path from iVALID.
- oREADY=0 in FLUSH, START, WAIT_ACK and WAIT_DONE. iVALID in those states sets oOVERRUN, and the sample is dropped. oOVERRUN clears only on reset.
- iFHT_RDY already low on entry to WAIT_ACK: advance in 1 cycle.
- iFHT_RDY toggling high during WAIT_ACK: ignored; the loader waits for the low level.
- Continuous iVALID=1 in LOAD: N transfers in N consecutive cycles with no bubbles.
- Gapped iVALID: k holds and no write is issued.
- Between frames, the earliest next transfer is the cycle after the WAIT_DONE exit.

Test Plan:
- A_BIT=2 (N=16), stream k=0..15 with data=k, iVALID held high. Required writes: k=1 → bank0 addr2; k=3 → bank0 addr3; k=6 → bank2 addr1; k=15 → bank3 addr3. 16 oWE pulses on consecutive cycles; oSTART exactly 2 cycles after the last transfer.
- Same frame with iVALID deasserted every other cycle → identical bank/addr/data sequence; oWE=0 in cycles after idle inputs; one oSTART.
- Model fht_control: iFHT_RDY falls 2 cycles after oSTART and rises 100 cycles later → oREADY=0 and oBUSY=1 throughout. oREADY rises the cycle after iFHT_RDY rises, and oBUSY falls with it. A second frame then loads correctly.
- iVALID high during WAIT_DONE → oOVERRUN=1 and stays 1 after the next frame; no oWE pulse during WAIT_DONE.
- iRESET asserted after 7 transfers → all outputs 0 asynchronously, no oSTART. After release, a full 16-sample frame writes k=0 to bank0 addr0.
- iFHT_RDY held high for 20 cycles after oSTART → loader remains in WAIT_ACK with oREADY=0. Then drop iFHT_RDY low for 5 cycles and raise it high → oREADY=1 the cycle after it rises.
